// File: rtl/freq_ctrl_pkg.sv
// Shared types, default constants and the reference PINC conversion for the
// DDS frequency step controller.
package freq_ctrl_pkg;

  typedef enum logic {NORM, LEARN} state_t;

  localparam int unsigned FREQ_W_DEF      = 16;
  localparam int unsigned F_MIN_DEF       = 1;
  localparam int unsigned F_MAX_DEF       = 30;
  localparam int unsigned F_STEP_DEF      = 1;
  localparam int unsigned LEARN_START_DEF = 10;
  localparam int unsigned LEARN_STEP_DEF  = 2;
  localparam int unsigned LEARN_STOP_DEF  = 30;
  localparam int unsigned PINC_W_DEF      = 24;
  localparam int unsigned PINC_NUM_DEF    = 41943;
  localparam int unsigned PINC_SHIFT_DEF  = 10;

  // Rounded phase increment for a frequency, using the default scaling.
  function automatic longint unsigned pinc_of(input longint unsigned f);
    longint unsigned p;
    p = (f * longint'(PINC_NUM_DEF) + (64'd1 << (PINC_SHIFT_DEF - 1))) >> PINC_SHIFT_DEF;
    return p & ((64'd1 << PINC_W_DEF) - 64'd1);
  endfunction

endpackage

// File: rtl/key_edge.sv
// Active-low key conditioner: 2-flop synchroniser, falling-edge event and
// hold-to-repeat timer.
module key_edge #(
  parameter int unsigned HOLD_CYC = 25_000_000,
  parameter int unsigned REP_CYC  = 5_000_000
) (
  input  logic clk_50m,
  input  logic rst,
  input  logic key_n,
  input  logic clr,
  output logic evt
);

  localparam int unsigned CNT_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  logic             s1, s2, prev;
  logic             rep;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] target;
  logic             fall, hit;

  assign fall   = prev & ~s2;
  assign target = rep ? CNT_W'(REP_CYC) : CNT_W'(HOLD_CYC);
  // cnt counts cycles since the last event, so a hit lands exactly HOLD_CYC
  // (first repeat) or REP_CYC (later repeats) cycles after it.
  assign hit    = (HOLD_CYC != 0) && !s2 && !clr && !fall && (cnt == target);
  assign evt    = fall | hit;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
      cnt  <= '0;
      rep  <= 1'b0;
    end else begin
      s1   <= key_n;
      s2   <= s1;
      prev <= s2;
      if (clr || s2) begin
        cnt <= '0;
        rep <= 1'b0;
      end else if (fall) begin
        cnt <= CNT_W'(1);
        rep <= 1'b0;
      end else if (hit) begin
        cnt <= CNT_W'(1);
        rep <= 1'b1;
      end else if (HOLD_CYC != 0) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/freq_step_ctrl.sv
// Key/learn-sweep frequency controller feeding a rounded DDS phase increment
// with a one-cycle valid strobe per distinct frequency.
module freq_step_ctrl
  import freq_ctrl_pkg::*;
#(
  parameter int unsigned FREQ_W      = FREQ_W_DEF,
  parameter int unsigned F_MIN       = F_MIN_DEF,
  parameter int unsigned F_MAX       = F_MAX_DEF,
  parameter int unsigned F_STEP      = F_STEP_DEF,
  parameter int unsigned WRAP        = 1,
  parameter int unsigned LEARN_START = LEARN_START_DEF,
  parameter int unsigned LEARN_STEP  = LEARN_STEP_DEF,
  parameter int unsigned LEARN_STOP  = LEARN_STOP_DEF,
  parameter int unsigned HOLD_CYC    = 25_000_000,
  parameter int unsigned REP_CYC     = 5_000_000,
  parameter int unsigned PINC_W      = PINC_W_DEF,
  parameter int unsigned PINC_NUM    = PINC_NUM_DEF,
  parameter int unsigned PINC_SHIFT  = PINC_SHIFT_DEF
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic [1:0]        key,
  input  logic              learn_en,
  input  logic              next_freq,
  output logic [FREQ_W-1:0] freq,
  output logic              learn_busy,
  output logic              learn_done,
  output logic [PINC_W-1:0] pinc,
  output logic              pinc_valid
);

  localparam int unsigned FW1    = FREQ_W + 1;
  localparam int unsigned PROD_W = FREQ_W + 32;

  state_t            state;
  logic [FREQ_W-1:0] saved;
  logic              dn_evt, up_evt, key_clr;
  logic [1:0]        le_sync, nf_sync;
  logic              le_prev, nf_prev;
  logic              le_rise, le_fall, nf_rise;

  assign key_clr = (state == LEARN);

  key_edge #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_key_dn (
    .clk_50m (clk_50m),
    .rst     (rst),
    .key_n   (key[0]),
    .clr     (key_clr),
    .evt     (dn_evt)
  );

  key_edge #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_key_up (
    .clk_50m (clk_50m),
    .rst     (rst),
    .key_n   (key[1]),
    .clr     (key_clr),
    .evt     (up_evt)
  );

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      le_sync <= '0;
      nf_sync <= '0;
      le_prev <= 1'b0;
      nf_prev <= 1'b0;
    end else begin
      le_sync <= {le_sync[0], learn_en};
      nf_sync <= {nf_sync[0], next_freq};
      le_prev <= le_sync[1];
      nf_prev <= nf_sync[1];
    end
  end

  assign le_rise =  le_sync[1] & ~le_prev;
  assign le_fall = ~le_sync[1] &  le_prev;
  assign nf_rise =  nf_sync[1] & ~nf_prev;

  // Next-value arithmetic in FREQ_W+1 bits so range compares cannot overflow.
  logic [FW1-1:0]    f_ext, up_sum, lr_sum;
  logic              dn_below, up_above, lr_ok;
  logic [FREQ_W-1:0] dn_val, up_val;

  always_comb begin
    f_ext    = {1'b0, freq};
    dn_below = f_ext < (FW1'(F_MIN) + FW1'(F_STEP));
    up_sum   = f_ext + FW1'(F_STEP);
    up_above = up_sum > FW1'(F_MAX);
    lr_sum   = f_ext + FW1'(LEARN_STEP);
    lr_ok    = lr_sum <= FW1'(LEARN_STOP);
    if (dn_below) dn_val = (WRAP != 0) ? FREQ_W'(F_MAX) : FREQ_W'(F_MIN);
    else          dn_val = freq - FREQ_W'(F_STEP);
    if (up_above) up_val = (WRAP != 0) ? FREQ_W'(F_MIN) : FREQ_W'(F_MAX);
    else          up_val = up_sum[FREQ_W-1:0];
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state      <= NORM;
      freq       <= FREQ_W'(F_MIN);
      saved      <= FREQ_W'(F_MIN);
      learn_busy <= 1'b0;
      learn_done <= 1'b0;
    end else begin
      learn_done <= 1'b0;
      case (state)
        NORM: begin
          if (le_rise) begin
            saved      <= freq;
            freq       <= FREQ_W'(LEARN_START);
            learn_busy <= 1'b1;
            state      <= LEARN;
          end else if (dn_evt) begin
            freq <= dn_val;
          end else if (up_evt) begin
            freq <= up_val;
          end
        end
        LEARN: begin
          if (le_fall) begin
            freq       <= saved;
            learn_busy <= 1'b0;
            state      <= NORM;
          end else if (nf_rise) begin
            if (lr_ok) freq <= lr_sum[FREQ_W-1:0];
            else       learn_done <= 1'b1;
          end
        end
        default: state <= NORM;
      endcase
    end
  end

  // PINC pipeline: any change of freq (plus one primed pass after reset)
  // launches a valid token that travels alongside the product.
  logic [FREQ_W-1:0] freq_d;
  logic              init_p, v1;
  logic [PROD_W-1:0] prod, rnd;

  assign rnd = prod + (PROD_W'(1) << (PINC_SHIFT - 1));

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      freq_d     <= FREQ_W'(F_MIN);
      init_p     <= 1'b1;
      v1         <= 1'b0;
      prod       <= '0;
      pinc       <= '0;
      pinc_valid <= 1'b0;
    end else begin
      freq_d     <= freq;
      init_p     <= 1'b0;
      v1         <= (freq != freq_d) | init_p;
      prod       <= PROD_W'(freq) * PROD_W'(PINC_NUM);
      pinc       <= PINC_W'(rnd >> PINC_SHIFT);
      pinc_valid <= v1;
    end
  end

endmodule

// File: tb/tb_freq_step_ctrl.sv
// Scoreboard bench for freq_step_ctrl: a wrapping and a saturating instance,
// expected PINC words queued on every modelled frequency change.
module tb_freq_step_ctrl;
  import freq_ctrl_pkg::*;

  localparam int HOLD = 20;
  localparam int REP  = 5;

  logic        clk_50m = 1'b0;
  logic        rst     = 1'b1;
  logic [1:0]  key_w   = 2'b11;
  logic [1:0]  key_s   = 2'b11;
  logic        learn_en  = 1'b0;
  logic        next_freq = 1'b0;
  logic        le_s = 1'b0;
  logic        nf_s = 1'b0;

  logic [15:0] freq_w, freq_s;
  logic        busy_w, busy_s, done_w, done_s, pv_w, pv_s;
  logic [23:0] pinc_w, pinc_s;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int exp_w = 1;
  int exp_s = 1;
  longint unsigned q_w[$];
  longint unsigned q_s[$];

  always #10 clk_50m = ~clk_50m;

  freq_step_ctrl #(.WRAP(1), .HOLD_CYC(HOLD), .REP_CYC(REP)) dut_w (
    .clk_50m(clk_50m), .rst(rst), .key(key_w), .learn_en(learn_en),
    .next_freq(next_freq), .freq(freq_w), .learn_busy(busy_w),
    .learn_done(done_w), .pinc(pinc_w), .pinc_valid(pv_w)
  );

  freq_step_ctrl #(.WRAP(0), .HOLD_CYC(HOLD), .REP_CYC(REP)) dut_s (
    .clk_50m(clk_50m), .rst(rst), .key(key_s), .learn_en(le_s),
    .next_freq(nf_s), .freq(freq_s), .learn_busy(busy_s),
    .learn_done(done_s), .pinc(pinc_s), .pinc_valid(pv_s)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk_50m) begin
    if (!rst) begin
      if (done_w) done_cnt++;
      if (pv_w) begin
        if (q_w.size() == 0) chk("pv_w_unexpected", 1, 0);
        else chk("pinc_w", pinc_w, q_w.pop_front());
      end
      if (pv_s) begin
        if (q_s.size() == 0) chk("pv_s_unexpected", 1, 0);
        else chk("pinc_s", pinc_s, q_s.pop_front());
      end
    end
  end

  function automatic int step_f(input int f, input bit up, input bit wrap);
    if (up) return (f + 1 > 30) ? (wrap ? 1 : 30) : f + 1;
    return (f - 1 < 1) ? (wrap ? 30 : 1) : f - 1;
  endfunction

  task automatic model_key(input bit sat, input bit up);
    int n;
    if (sat) begin
      n = step_f(exp_s, up, 1'b0);
      if (n != exp_s) q_s.push_back(pinc_of(longint'(n)));
      exp_s = n;
    end else begin
      n = step_f(exp_w, up, 1'b1);
      if (n != exp_w) q_w.push_back(pinc_of(longint'(n)));
      exp_w = n;
    end
  endtask

  task automatic set_w(input int n);
    if (n != exp_w) q_w.push_back(pinc_of(longint'(n)));
    exp_w = n;
  endtask

  // Hold pattern k for n cycles; events at offset 0 and then HOLD, HOLD+REP, ...
  task automatic press(input bit sat, input logic [1:0] k, input int n);
    int ev;
    ev = 1;
    if (n > HOLD) ev += (n - HOLD - 1) / REP + 1;
    for (int i = 0; i < ev; i++) model_key(sat, k[0]);
    @(posedge clk_50m); #1;
    if (sat) key_s = k; else key_w = k;
    repeat (n) @(posedge clk_50m);
    #1;
    key_s = 2'b11;
    key_w = 2'b11;
    repeat (6) @(posedge clk_50m);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((q_w.size() != 0 || q_s.size() != 0) && c < 20) begin
      @(posedge clk_50m);
      c++;
    end
    @(negedge clk_50m);
    chk("drain_w", q_w.size(), 0);
    chk("drain_s", q_s.size(), 0);
  endtask

  task automatic nf_pulse();
    if (exp_w + 2 <= 30) set_w(exp_w + 2);
    @(posedge clk_50m); #1 next_freq = 1'b1;
    repeat (3) @(posedge clk_50m);
    #1 next_freq = 1'b0;
    repeat (3) @(posedge clk_50m);
  endtask

  task automatic do_reset();
    @(posedge clk_50m); #1;
    rst = 1'b1; learn_en = 1'b0; next_freq = 1'b0;
    key_w = 2'b11; key_s = 2'b11;
    repeat (3) @(posedge clk_50m);
    @(negedge clk_50m);
    chk("rst_freq_w", freq_w, 1);
    chk("rst_busy_w", busy_w, 0);
    chk("rst_done_w", done_w, 0);
    chk("rst_pinc_w", pinc_w, 0);
    chk("rst_pv_w", pv_w, 0);
    chk("rst_freq_s", freq_s, 1);
    exp_w = 1; exp_s = 1;
    q_w.push_back(pinc_of(1));
    q_s.push_back(pinc_of(1));
    @(posedge clk_50m); #1 rst = 1'b0;
    @(posedge clk_50m); @(negedge clk_50m);
    chk("pv_cyc1", pv_w, 0);
    @(posedge clk_50m); @(negedge clk_50m);
    chk("pv_cyc2", pv_w, 1);
    chk("pinc_cyc2", pinc_w, 41);
    @(posedge clk_50m); @(negedge clk_50m);
    chk("pv_cyc3", pv_w, 0);
    drain();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int ev_off[5];
    int e;
    ev_off = '{0, 20, 25, 30, 35};

    do_reset();
    chk("freq_after_rst", freq_w, 1);

    // Wrapping instance at both range ends.
    press(1'b0, 2'b10, 3);
    chk("wrap_dn_freq", freq_w, exp_w);
    press(1'b0, 2'b01, 3);
    chk("wrap_up_freq", freq_w, exp_w);

    // Saturating instance: hold at 1, climb by auto-repeat, hold at 30.
    press(1'b1, 2'b10, 3);
    chk("sat_lo_freq", freq_s, 1);
    press(1'b1, 2'b01, 182);
    chk("sat_climb_freq", freq_s, 30);
    drain();
    press(1'b1, 2'b01, 3);
    chk("sat_hi_freq", freq_s, 30);
    drain();

    // Both keys together: down wins.
    repeat (4) press(1'b0, 2'b01, 3);
    chk("freq5", freq_w, 5);
    press(1'b0, 2'b00, 3);
    chk("both_keys", freq_w, 4);
    drain();

    // Auto-repeat timing on a 40-cycle hold, checked every cycle.
    for (int i = 0; i < 5; i++) model_key(1'b0, 1'b1);
    @(posedge clk_50m); #1 key_w = 2'b01;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_50m); @(negedge clk_50m);
      e = 4;
      foreach (ev_off[j]) if (ev_off[j] + 3 <= k) e++;
      chk($sformatf("rep_k%0d", k), freq_w, e);
    end
    key_w = 2'b11;
    repeat (8) @(posedge clk_50m);
    @(negedge clk_50m);
    chk("rep_final", freq_w, 9);
    press(1'b0, 2'b10, 3);
    press(1'b0, 2'b10, 3);
    chk("freq7", freq_w, 7);
    drain();

    // Learn entry.
    set_w(10);
    @(posedge clk_50m); #1 learn_en = 1'b1;
    repeat (2) @(posedge clk_50m);
    @(negedge clk_50m);
    chk("learn_pre_freq", freq_w, 7);
    chk("learn_pre_busy", busy_w, 0);
    @(posedge clk_50m); @(negedge clk_50m);
    chk("learn_freq", freq_w, 10);
    chk("learn_busy", busy_w, 1);

    // Sweep to the end; only the 11th edge reports done.
    repeat (10) nf_pulse();
    chk("sweep_freq", freq_w, 30);
    chk("sweep_done_early", done_cnt, 0);
    nf_pulse();
    chk("sweep_done", done_cnt, 1);
    chk("sweep_hold", freq_w, 30);
    drain();

    // Exit coincident with a next_freq edge.
    set_w(7);
    @(posedge clk_50m); #1 learn_en = 1'b0; next_freq = 1'b1;
    repeat (3) @(posedge clk_50m);
    @(negedge clk_50m);
    chk("exit_freq", freq_w, 7);
    chk("exit_busy", busy_w, 0);
    next_freq = 1'b0;
    repeat (4) @(posedge clk_50m);
    chk("exit_done", done_cnt, 1);
    drain();

    // Reset mid-learn at 14.
    set_w(10);
    @(posedge clk_50m); #1 learn_en = 1'b1;
    repeat (5) @(posedge clk_50m);
    nf_pulse();
    nf_pulse();
    @(negedge clk_50m);
    chk("mid_freq", freq_w, 14);
    chk("mid_busy", busy_w, 1);
    drain();
    do_reset();
    chk("post_rst_freq", freq_w, 1);
    chk("post_rst_busy", busy_w, 0);
    repeat (5) @(posedge clk_50m);
    @(negedge clk_50m);
    chk("post_rst_hold", freq_w, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
